pc_seq: RTL

Fetch sequencer that drives the program counter's control interface: `pc_op[1:0]` and `pc_in[15:0]`. The PC operations are 0 = clear, 1 = load `pc_in`, 2 = increment, 3 = hold/restore last loaded-or-incremented value. The block sits between the PC register and instruction memory. It boots the PC to a reset vector, paces instruction fetches with a memory ready handshake, applies branch redirects and handles halt/resume. It also flags memory stall timeouts.

---
 rtl/pc_seq_if.sv | 29 ++
 rtl/pc_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_if.sv
// Bus between the fetch sequencer, the PC register and instruction memory.
// The sequencer drives the PC control code, the load value and the fetch
// request. Memory and branch logic drive the accept and redirect signals.
interface pc_seq_if;
    logic [1:0]  pc_op;       // 0 clear, 1 load pc_in, 2 increment, 3 hold
    logic [15:0] pc_in;       // PC load value, meaningful when pc_op == 1
    logic        fetch_req;   // PC output is a valid fetch address
    logic        imem_ready;  // memory accepts the current fetch
    logic        br_valid;    // branch taken, sampled only on an accept edge
    logic [15:0] br_target;   // branch destination

    modport master (
        output pc_op,
        output pc_in,
        output fetch_req,
        input  imem_ready,
        input  br_valid,
        input  br_target
    );

    modport slave (
        input  pc_op,
        input  pc_in,
        input  fetch_req,
        output imem_ready,
        output br_valid,
        output br_target
    );
endinterface

// File: rtl/pc_seq.sv
// Fetch sequencer: boots the PC to RESET_VEC, paces fetches against the
// memory ready signal, applies branch redirects, and handles halt/resume
// along with a sticky stall-timeout flag.
//
// Handshake: a fetch transfers on a rising edge where fetch_req and
// imem_ready are both high. fetch_req stays high until that transfer,
// unless a stall timeout or a halt request abandons the fetch. It drops
// for exactly one ADVANCE cycle after each transfer, while the PC applies
// the increment or branch load. This ADVANCE bubble means fetch_req never
// presents a stale PC.
module pc_seq #(
    parameter logic [15:0] RESET_VEC = 16'h0000,
    parameter int unsigned MAX_STALL = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        halt_req,
    input  logic        resume,
    pc_seq_if.master    bus,
    output logic        halted,
    output logic        err,
    output logic [15:0] inst_cnt,
    output logic [2:0]  dbg_state
);

    localparam int SW = $clog2(MAX_STALL + 1);
    // Stall count value at which one more not-ready cycle is a timeout.
    localparam logic [SW-1:0] STALL_LAST = SW'(MAX_STALL - 1);

    localparam logic [1:0] OP_CLR  = 2'd0;
    localparam logic [1:0] OP_LOAD = 2'd1;
    localparam logic [1:0] OP_INC  = 2'd2;
    localparam logic [1:0] OP_HOLD = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FETCH = 3'd2,
        S_ADV   = 3'd3,
        S_HALT  = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    pc_op_q, pc_op_d;
    logic [15:0]   pc_in_q, pc_in_d;
    logic          fetch_q, fetch_d;
    logic          halted_q, halted_d;
    logic          err_q, err_d;
    logic          pend_q, pend_d;
    logic [SW-1:0] stall_q, stall_d;
    logic [15:0]   inst_cnt_q;
    logic [15:0]   inst_cnt_d;
    logic          cnt_inc;
    logic          cnt_clr;
    logic          take_br;

    // An accept with br_valid high turns the following ADVANCE into a load.
    assign take_br = (state_q == S_FETCH) && bus.imem_ready && bus.br_valid;

    // The instruction counter wraps naturally at 16 bits.
    assign inst_cnt_d = cnt_clr ? 16'h0000 :
                        cnt_inc ? inst_cnt_q + 16'd1 : inst_cnt_q;

    // Next-state logic and the registered Moore outputs for the next state.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        pend_d  = pend_q;
        stall_d = stall_q;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        pc_op_d = OP_HOLD;
        pc_in_d = pc_in_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_clr = 1'b1;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // Accept beats timeout, which beats halt_req.
                if (bus.imem_ready) begin
                    state_d = S_ADV;
                    cnt_inc = 1'b1;
                    stall_d = '0;
                    if (halt_req) begin
                        pend_d = 1'b1;
                    end
                end else if (stall_q == STALL_LAST) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                    stall_d = '0;
                end else if (halt_req) begin
                    state_d = S_HALT;
                    stall_d = '0;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            S_ADV: begin
                if (pend_q) begin
                    state_d = S_HALT;
                    pend_d  = 1'b0;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_clr = 1'b1;
                    err_d   = 1'b0;
                end else if (resume) begin
                    state_d = S_FETCH;
                    err_d   = 1'b0;
                    stall_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs follow the state being entered, so each one is a register.
        unique case (state_d)
            S_IDLE: begin
                pc_op_d = OP_CLR;
            end
            S_LOAD: begin
                pc_op_d = OP_LOAD;
                pc_in_d = RESET_VEC;
            end
            S_ADV: begin
                if (take_br) begin
                    pc_op_d = OP_LOAD;
                    pc_in_d = bus.br_target;
                end else begin
                    pc_op_d = OP_INC;
                end
            end
            default: begin
                pc_op_d = OP_HOLD;
            end
        endcase

        fetch_d  = (state_d == S_FETCH);
        halted_d = (state_d == S_HALT);
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_op_q    <= OP_CLR;
            pc_in_q    <= RESET_VEC;
            fetch_q    <= 1'b0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
            pend_q     <= 1'b0;
            stall_q    <= '0;
            inst_cnt_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_op_q    <= pc_op_d;
            pc_in_q    <= pc_in_d;
            fetch_q    <= fetch_d;
            halted_q   <= halted_d;
            err_q      <= err_d;
            pend_q     <= pend_d;
            stall_q    <= stall_d;
            inst_cnt_q <= inst_cnt_d;
        end
    end

    assign bus.pc_op     = pc_op_q;
    assign bus.pc_in     = pc_in_q;
    assign bus.fetch_req = fetch_q;
    assign halted        = halted_q;
    assign err           = err_q;
    assign inst_cnt      = inst_cnt_q;
    assign dbg_state     = state_q;

endmodule
